// File: rtl/bus_mem_dev.sv
// Clocked word-addressed RAM/ROM target on the shared tri-state system bus,
// with address window decode, programmable wait states and a ready/error handshake.
module bus_mem_dev #(
  parameter int    DW          = 16,
  parameter int    AW          = 23,
  parameter int    DEPTH       = 1024,
  parameter int    BASE        = 0,
  parameter int    ROM_WORDS   = 0,
  parameter int    WAIT_STATES = 1,
  parameter string INIT_FILE   = "data.bin"
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [AW-1:0] BUS_A,
  inout  logic [DW-1:0] BUS_D,
  input  logic          BUS_R,
  input  logic          BUS_W,
  output logic          BUS_RDY,
  output logic          BUS_ERR
);

  localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] LO      = (AW+1)'(BASE);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [3:0]  WS      = 4'(WAIT_STATES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE, ST_HOLD} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          wr_q, wr_d;
  logic          ill_q, ill_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rdy_q, rdy_d;
  logic          err_q, err_d;
  logic          drv_q, drv_d;

  logic [DW-1:0] mem_q [DEPTH];

  logic [AW:0]   off;
  logic          hit, req, rom, mem_we;

  // An address below BASE wraps to >= 2^AW, so one unsigned compare covers both bounds.
  assign off = {1'b0, BUS_A} - LO;
  assign hit = off < DEPTH_W;
  assign req = BUS_R | BUS_W;
  assign rom = int'(idx_q) < ROM_WORDS;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      ill_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      drv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      ill_q   <= ill_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      drv_q   <= drv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (hit && req) begin
          if (WS == 4'd0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WS;
          end
        end
      end
      ST_WAIT: begin
        if (!req) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= 4'd1) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: state_d = ST_HOLD;
      ST_HOLD: if (!req) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs are registered on the DONE edge, giving WAIT_STATES+1 edges of latency.
  always_comb begin
    idx_d   = idx_q;
    wr_d    = wr_q;
    ill_d   = ill_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rdy_d   = rdy_q;
    err_d   = err_q;
    drv_d   = drv_q;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hit && req) begin
          idx_d   = off[IW-1:0];
          wr_d    = BUS_W;
          ill_d   = BUS_R & BUS_W;
          wdata_d = BUS_D;
        end
      end
      ST_DONE: begin
        rdy_d   = 1'b1;
        err_d   = ill_q | (wr_q & rom);
        drv_d   = ~wr_q & ~ill_q;
        rdata_d = mem_q[idx_q];
        mem_we  = wr_q & ~ill_q & ~rom;
      end
      ST_HOLD: begin
        if (!req) begin
          rdy_d = 1'b0;
          err_d = 1'b0;
          drv_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[idx_q] <= wdata_q;
  end

  assign BUS_D   = drv_q ? rdata_q : 'z;
  assign BUS_RDY = rdy_q;
  assign BUS_ERR = err_q;

endmodule

// File: tb/tb_bus_mem_dev.sv
// Directed bench for bus_mem_dev: five instances with different parameter sets,
// a table of accesses plus hand-written abort/reset sequences.
module tb_bus_mem_dev;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [5];
  logic [22:0] a     [5];
  logic        r     [5];
  logic        w     [5];
  logic        de    [5];
  logic [15:0] dd    [5];
  logic        rdy_o [5];
  logic        err_o [5];
  wire  [15:0] d0, d1, d2, d3, d4;

  // Undriven bus reads back as all ones.
  pullup (d0);
  pullup (d1);
  pullup (d2);
  pullup (d3);
  pullup (d4);

  assign d0 = de[0] ? dd[0] : 'z;
  assign d1 = de[1] ? dd[1] : 'z;
  assign d2 = de[2] ? dd[2] : 'z;
  assign d3 = de[3] ? dd[3] : 'z;
  assign d4 = de[4] ? dd[4] : 'z;

  bus_mem_dev #(.INIT_FILE("")) u_main (
    .CLK(clk), .RST_N(rst_n[0]), .BUS_A(a[0]), .BUS_D(d0), .BUS_R(r[0]), .BUS_W(w[0]),
    .BUS_RDY(rdy_o[0]), .BUS_ERR(err_o[0]));

  bus_mem_dev #(.ROM_WORDS(2), .INIT_FILE("")) u_rom (
    .CLK(clk), .RST_N(rst_n[1]), .BUS_A(a[1]), .BUS_D(d1), .BUS_R(r[1]), .BUS_W(w[1]),
    .BUS_RDY(rdy_o[1]), .BUS_ERR(err_o[1]));

  bus_mem_dev #(.BASE(32'h100), .DEPTH(16), .INIT_FILE("")) u_win (
    .CLK(clk), .RST_N(rst_n[2]), .BUS_A(a[2]), .BUS_D(d2), .BUS_R(r[2]), .BUS_W(w[2]),
    .BUS_RDY(rdy_o[2]), .BUS_ERR(err_o[2]));

  bus_mem_dev #(.WAIT_STATES(0), .INIT_FILE("")) u_ws0 (
    .CLK(clk), .RST_N(rst_n[3]), .BUS_A(a[3]), .BUS_D(d3), .BUS_R(r[3]), .BUS_W(w[3]),
    .BUS_RDY(rdy_o[3]), .BUS_ERR(err_o[3]));

  bus_mem_dev #(.WAIT_STATES(3), .INIT_FILE("")) u_ws3 (
    .CLK(clk), .RST_N(rst_n[4]), .BUS_A(a[4]), .BUS_D(d4), .BUS_R(r[4]), .BUS_W(w[4]),
    .BUS_RDY(rdy_o[4]), .BUS_ERR(err_o[4]));

  typedef struct {
    int          inst;
    logic [22:0] addr;
    logic        rd;
    logic        wr;
    logic [15:0] wdata;
    int          lat;
    logic        err;
    logic        chk;
    logic [15:0] data;
    int          hold;
  } vec_t;

  vec_t vecs [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [15:0] bus_d(input int i);
    case (i)
      0:       return d0;
      1:       return d1;
      2:       return d2;
      3:       return d3;
      default: return d4;
    endcase
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s #%0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input int inst, input logic [22:0] addr, input logic rd, input logic wr,
                     input logic [15:0] wd, input int lat, input logic err, input logic chk,
                     input logic [15:0] data, input int hold);
    vec_t v;
    v.inst = inst; v.addr = addr; v.rd = rd; v.wr = wr; v.wdata = wd;
    v.lat = lat; v.err = err; v.chk = chk; v.data = data; v.hold = hold;
    vecs.push_back(v);
  endtask

  // One bus access: lat is edges from request sample to BUS_RDY (-1 if it never rises).
  // Address and write data are scrambled right after the sample edge.
  task automatic access(input int i, input logic [22:0] addr, input logic rd, input logic wr,
                        input logic [15:0] wdata, input int hold, output int lat,
                        output logic [15:0] data, output logic err, output logic rel_ok,
                        output logic hold_ok);
    lat = -1;
    rel_ok = 1'b1;
    hold_ok = 1'b1;
    @(negedge clk);
    a[i] = addr; r[i] = rd; w[i] = wr; dd[i] = wdata; de[i] = wr & ~rd;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) begin
        a[i]  = addr ^ 23'h1;
        dd[i] = ~wdata;
      end
      if (rdy_o[i]) begin
        lat = k;
        break;
      end
    end
    data = bus_d(i);
    err  = err_o[i];
    if (lat >= 0) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (rdy_o[i] !== 1'b1 || bus_d(i) !== data || err_o[i] !== err) hold_ok = 1'b0;
      end
    end
    r[i] = 1'b0; w[i] = 1'b0; de[i] = 1'b0;
    @(negedge clk);
    if (rdy_o[i] !== 1'b0 || err_o[i] !== 1'b0 || bus_d(i) !== 16'hFFFF) rel_ok = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [15:0] data;
    logic        err, rel_ok, hold_ok, seen;

    for (int i = 0; i < 5; i++) begin
      rst_n[i] = 1'b0; a[i] = '0; r[i] = 1'b0; w[i] = 1'b0; de[i] = 1'b0; dd[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("reset_rdy", i, 32'(rdy_o[i]), 0);
      check("reset_err", i, 32'(err_o[i]), 0);
      check("reset_bus_d", i, 32'(bus_d(i)), 32'hFFFF);
    end
    for (int i = 0; i < 5; i++) rst_n[i] = 1'b1;

    //   inst addr       rd wr wdata     lat err chk data     hold
    add(0, 23'h000000, 0, 1, 16'h1111, 2, 0, 0, 16'h0000, 0);
    add(0, 23'h000001, 0, 1, 16'h2222, 2, 0, 0, 16'h0000, 0);
    add(0, 23'h000002, 0, 1, 16'h3333, 2, 0, 0, 16'h0000, 0);
    add(0, 23'h000003, 0, 1, 16'h4444, 2, 0, 0, 16'h0000, 0);
    add(0, 23'h000002, 1, 0, 16'h0000, 2, 0, 1, 16'h3333, 2);
    add(0, 23'h000000, 0, 1, 16'h4321, 2, 0, 0, 16'h0000, 0);
    add(0, 23'h000001, 0, 1, 16'hDCBA, 2, 0, 0, 16'h0000, 0);
    add(0, 23'h000002, 0, 1, 16'h9876, 2, 0, 0, 16'h0000, 0);
    add(0, 23'h000000, 1, 0, 16'h0000, 2, 0, 1, 16'h4321, 0);
    add(0, 23'h000001, 1, 0, 16'h0000, 2, 0, 1, 16'hDCBA, 0);
    add(0, 23'h000002, 1, 0, 16'h0000, 2, 0, 1, 16'h9876, 3);
    add(0, 23'h000003, 1, 0, 16'h0000, 2, 0, 1, 16'h4444, 0);
    add(0, 23'h000003, 1, 1, 16'h5555, 2, 1, 1, 16'hFFFF, 1);
    add(0, 23'h000003, 1, 0, 16'h0000, 2, 0, 1, 16'h4444, 0);
    add(1, 23'h000001, 0, 1, 16'hBEEF, 2, 1, 0, 16'h0000, 1);
    add(1, 23'h000000, 0, 1, 16'h1234, 2, 1, 0, 16'h0000, 0);
    add(1, 23'h000002, 0, 1, 16'h5A5A, 2, 0, 0, 16'h0000, 0);
    add(1, 23'h000002, 1, 0, 16'h0000, 2, 0, 1, 16'h5A5A, 0);
    add(2, 23'h000100, 0, 1, 16'h1111, 2, 0, 0, 16'h0000, 0);
    add(2, 23'h00010F, 0, 1, 16'h7777, 2, 0, 0, 16'h0000, 0);
    add(2, 23'h0000FF, 1, 0, 16'h0000, -1, 0, 1, 16'hFFFF, 0);
    add(2, 23'h000110, 1, 0, 16'h0000, -1, 0, 1, 16'hFFFF, 0);
    add(2, 23'h000110, 0, 1, 16'hBBBB, -1, 0, 0, 16'h0000, 0);
    add(2, 23'h0000FF, 0, 1, 16'hCCCC, -1, 0, 0, 16'h0000, 0);
    add(2, 23'h000100, 1, 0, 16'h0000, 2, 0, 1, 16'h1111, 0);
    add(2, 23'h00010F, 1, 0, 16'h0000, 2, 0, 1, 16'h7777, 0);
    add(3, 23'h000005, 0, 1, 16'h1357, 1, 0, 0, 16'h0000, 0);
    add(3, 23'h000005, 1, 0, 16'h0000, 1, 0, 1, 16'h1357, 1);
    add(3, 23'h000005, 1, 1, 16'h0F0F, 1, 1, 1, 16'hFFFF, 0);
    add(3, 23'h000005, 1, 0, 16'h0000, 1, 0, 1, 16'h1357, 0);
    add(4, 23'h000005, 0, 1, 16'h2468, 4, 0, 0, 16'h0000, 0);
    add(4, 23'h000005, 1, 0, 16'h0000, 4, 0, 1, 16'h2468, 1);

    for (int n = 0; n < vecs.size(); n++) begin
      access(vecs[n].inst, vecs[n].addr, vecs[n].rd, vecs[n].wr, vecs[n].wdata, vecs[n].hold,
             lat, data, err, rel_ok, hold_ok);
      check("latency", n, lat, vecs[n].lat);
      check("bus_err", n, 32'(err), 32'(vecs[n].err));
      if (vecs[n].chk) check("read_data", n, 32'(data), 32'(vecs[n].data));
      check("release", n, 32'(rel_ok), 1);
      if (vecs[n].hold > 0) check("hold_stable", n, 32'(hold_ok), 1);
    end

    // ROM words had no image; they must simply not have taken the rejected writes.
    access(1, 23'h000001, 1'b1, 1'b0, 16'h0000, 0, lat, data, err, rel_ok, hold_ok);
    check("rom_rd_lat", 1, lat, 2);
    check("rom_word1_kept", 1, 32'(data === 16'hBEEF), 0);
    access(1, 23'h000000, 1'b1, 1'b0, 16'h0000, 0, lat, data, err, rel_ok, hold_ok);
    check("rom_word0_kept", 0, 32'(data === 16'h1234), 0);

    // Aborted write: strobes drop while in WAIT.
    access(4, 23'h000006, 1'b0, 1'b1, 16'h1111, 0, lat, data, err, rel_ok, hold_ok);
    check("abort_pre_lat", 0, lat, 4);
    @(negedge clk);
    a[4] = 23'h000006; w[4] = 1'b1; dd[4] = 16'h2222; de[4] = 1'b1;
    repeat (2) @(negedge clk);
    w[4] = 1'b0; de[4] = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rdy_o[4] !== 1'b0) seen = 1'b1;
    end
    check("abort_no_rdy", 0, 32'(seen), 0);
    access(4, 23'h000006, 1'b1, 1'b0, 16'h0000, 0, lat, data, err, rel_ok, hold_ok);
    check("abort_mem_kept", 0, 32'(data), 32'h1111);

    // Reset in WAIT of a write: write is dropped.
    @(negedge clk);
    a[0] = 23'h000003; w[0] = 1'b1; dd[0] = 16'hAAAA; de[0] = 1'b1;
    @(negedge clk);
    #1 rst_n[0] = 1'b0;
    #1;
    check("rst_wait_rdy", 0, 32'(rdy_o[0]), 0);
    check("rst_wait_err", 0, 32'(err_o[0]), 0);
    w[0] = 1'b0; de[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1;
    access(0, 23'h000003, 1'b1, 1'b0, 16'h0000, 0, lat, data, err, rel_ok, hold_ok);
    check("rst_wait_lat", 0, lat, 2);
    check("rst_wait_mem_kept", 0, 32'(data), 32'h4444);

    // Reset in HOLD of a read: outputs release immediately.
    @(negedge clk);
    a[0] = 23'h000002; r[0] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rdy_o[0]) begin
        seen = 1'b1;
        break;
      end
    end
    check("rst_hold_rdy_seen", 0, 32'(seen), 1);
    check("rst_hold_data", 0, 32'(bus_d(0)), 32'h9876);
    #2 rst_n[0] = 1'b0;
    #1;
    check("rst_hold_rdy", 0, 32'(rdy_o[0]), 0);
    check("rst_hold_err", 0, 32'(err_o[0]), 0);
    check("rst_hold_bus_d", 0, 32'(bus_d(0)), 32'hFFFF);
    r[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1;
    access(0, 23'h000002, 1'b1, 1'b0, 16'h0000, 0, lat, data, err, rel_ok, hold_ok);
    check("post_rst_lat", 0, lat, 2);
    check("post_rst_data", 0, 32'(data), 32'h9876);
    check("post_rst_release", 0, 32'(rel_ok), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
